// File: rtl/axi4_lite_ctrl_regs_pkg.sv
// Shared definitions for the AXI4-Lite control register bank: register offsets,
// handshake FSM encodings and the address decoder.
package axi4_lite_ctrl_regs_pkg;

  localparam logic [31:0] REG_CONFIG    = 32'h00;
  localparam logic [31:0] REG_CONTROL   = 32'h04;
  localparam logic [31:0] REG_STATUS    = 32'h08;
  localparam logic [31:0] REG_IRQ_MASK  = 32'h0C;
  localparam logic [31:0] REG_IRQ_FLAGS = 32'h10;
  localparam logic [31:0] REG_SCRATCH   = 32'h14;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_DONE    = 2'd1,
    W_RELEASE = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_DONE    = 2'd1,
    R_RELEASE = 2'd2
  } r_state_e;

  typedef enum logic [2:0] {
    SEL_CONFIG,
    SEL_CONTROL,
    SEL_STATUS,
    SEL_IRQ_MASK,
    SEL_IRQ_FLAGS,
    SEL_SCRATCH,
    SEL_NONE
  } reg_sel_e;

  // Word-aligned decode: the two low address bits never select a register.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    logic [31:0] word;
    word = addr & ~32'h3;
    case (word)
      REG_CONFIG:    return SEL_CONFIG;
      REG_CONTROL:   return SEL_CONTROL;
      REG_STATUS:    return SEL_STATUS;
      REG_IRQ_MASK:  return SEL_IRQ_MASK;
      REG_IRQ_FLAGS: return SEL_IRQ_FLAGS;
      REG_SCRATCH:   return SEL_SCRATCH;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axi4_lite_req_ack.sv
// IDLE/DONE/RELEASE request handshake: accepts a held request exactly once and
// answers with a single registered ready pulse.
module axi4_lite_req_ack
  import axi4_lite_ctrl_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic accept,
  output logic ready
);

  // Read and write FSMs share one encoding, so the write names serve both.
  localparam logic [1:0] S_IDLE    = W_IDLE;
  localparam logic [1:0] S_DONE    = W_DONE;
  localparam logic [1:0] S_RELEASE = W_RELEASE;

  logic [1:0] state;

  assign accept = (state == S_IDLE) && req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b0;
    end else begin
      ready <= accept;
      case (state)
        S_IDLE:    if (req) state <= S_DONE;
        S_DONE:    state <= S_RELEASE;
        S_RELEASE: if (!req) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_ctrl_regs.sv
// Control/status register bank behind the AXI4-Lite write and read slaves:
// config, self-clearing control pulses, live status and sticky masked IRQ flags.
module axi4_lite_ctrl_regs
  import axi4_lite_ctrl_regs_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_req,
  input  logic [addr_width-1:0]   write_addr,
  input  logic [data_width-1:0]   s_axi_wdata,
  input  logic [data_width/8-1:0] s_axi_wstrb,
  output logic                    write_ready,
  output logic                    write_response,
  input  logic                    read_req,
  input  logic [addr_width-1:0]   read_addr,
  output logic                    read_ready,
  output logic [data_width-1:0]   read_value,
  output logic                    read_response,
  output logic [data_width-1:0]   cfg_out,
  output logic [data_width-1:0]   ctrl_pulse,
  input  logic [data_width-1:0]   status_in,
  input  logic [data_width-1:0]   irq_events,
  output logic                    irq_out
);

  function automatic logic [data_width-1:0] byte_mask(input logic [data_width/8-1:0] strb);
    logic [data_width-1:0] m;
    for (int i = 0; i < data_width/8; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  logic                  w_accept;
  logic                  r_accept;
  reg_sel_e              w_sel;
  reg_sel_e              r_sel;
  logic                  w_ok;
  logic                  r_ok;
  logic [data_width-1:0] w_mask;
  logic [data_width-1:0] w_bits;
  logic [data_width-1:0] w1c;
  logic [data_width-1:0] r_data;
  logic [data_width-1:0] irq_mask;
  logic [data_width-1:0] irq_flags;
  logic [data_width-1:0] scratch;

  axi4_lite_req_ack u_write_ack (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (write_req),
    .accept (w_accept),
    .ready  (write_ready)
  );

  axi4_lite_req_ack u_read_ack (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (read_req),
    .accept (r_accept),
    .ready  (read_ready)
  );

  // W-channel data is only valid in the accept cycle, so it is consumed directly.
  assign w_sel  = decode_addr(32'(write_addr));
  assign w_mask = byte_mask(s_axi_wstrb);
  assign w_bits = s_axi_wdata & w_mask;
  assign w_ok   = (w_sel != SEL_STATUS) && (w_sel != SEL_NONE);
  assign w1c    = (w_accept && (w_sel == SEL_IRQ_FLAGS)) ? w_bits : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out        <= '0;
      irq_mask       <= '0;
      scratch        <= '0;
      irq_flags      <= '0;
      ctrl_pulse     <= '0;
      write_response <= 1'b0;
      irq_out        <= 1'b0;
    end else begin
      ctrl_pulse     <= '0;
      write_response <= 1'b0;
      if (w_accept) begin
        write_response <= w_ok;
        case (w_sel)
          SEL_CONFIG:   cfg_out    <= (cfg_out & ~w_mask) | w_bits;
          SEL_CONTROL:  ctrl_pulse <= w_bits;
          SEL_IRQ_MASK: irq_mask   <= (irq_mask & ~w_mask) | w_bits;
          SEL_SCRATCH:  scratch    <= (scratch & ~w_mask) | w_bits;
          default:      ;
        endcase
      end
      // A new event on a bit being cleared this cycle keeps the flag set.
      irq_flags <= (irq_flags & ~w1c) | irq_events;
      irq_out   <= |(irq_flags & irq_mask);
    end
  end

  assign r_sel = decode_addr(32'(read_addr));

  always_comb begin
    r_data = '0;
    r_ok   = 1'b1;
    case (r_sel)
      SEL_CONFIG:    r_data = cfg_out;
      SEL_CONTROL:   r_data = '0;
      SEL_STATUS:    r_data = status_in;
      SEL_IRQ_MASK:  r_data = irq_mask;
      SEL_IRQ_FLAGS: r_data = irq_flags;
      SEL_SCRATCH:   r_data = scratch;
      default:       r_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_value    <= '0;
      read_response <= 1'b0;
    end else if (r_accept) begin
      read_value    <= r_data;
      read_response <= r_ok;
    end
  end

endmodule

// File: tb/tb_axi4_lite_ctrl_regs.sv
// Directed bench for axi4_lite_ctrl_regs with a register-map reference model
// compared against the DUT on every falling clock edge.
module tb_axi4_lite_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_req;
  logic [6:0]  write_addr;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        write_ready;
  logic        write_response;
  logic        read_req;
  logic [6:0]  read_addr;
  logic        read_ready;
  logic [31:0] read_value;
  logic        read_response;
  logic [31:0] cfg_out;
  logic [31:0] ctrl_pulse;
  logic [31:0] status_in;
  logic [31:0] irq_events;
  logic        irq_out;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  always #5 clk = ~clk;

  axi4_lite_ctrl_regs #(.addr_width(7), .data_width(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_req      (write_req),
    .write_addr     (write_addr),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .write_ready    (write_ready),
    .write_response (write_response),
    .read_req       (read_req),
    .read_addr      (read_addr),
    .read_ready     (read_ready),
    .read_value     (read_value),
    .read_response  (read_response),
    .cfg_out        (cfg_out),
    .ctrl_pulse     (ctrl_pulse),
    .status_in      (status_in),
    .irq_events     (irq_events),
    .irq_out        (irq_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register file indexed by word address, plus per-side
  // "request outstanding" bookkeeping (one ack per held request).
  logic [31:0] m_reg [0:31];
  logic        e_wready, e_wresp, e_rready, e_rresp, e_irq;
  logic [31:0] e_ctrl, e_rdata, mdl_m, mdl_w1c;
  bit          w_open, r_open;
  int          w_age, r_age, wi, ri;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      e_wready = 0; e_wresp = 0; e_rready = 0; e_rresp = 0; e_irq = 0;
      e_ctrl = '0; e_rdata = '0;
      w_open = 0; r_open = 0; w_age = 0; r_age = 0;
    end else begin
      e_irq    = |(m_reg[3] & m_reg[4]);
      e_wready = 0; e_wresp = 0; e_ctrl = '0; e_rready = 0; mdl_w1c = '0;
      // reads observe the registers as they were before this edge's write
      if (r_open) begin
        if (r_age >= 1 && !read_req) r_open = 0;
        r_age++;
      end else if (read_req) begin
        ri = int'(read_addr) >> 2;
        r_open = 1; r_age = 0; e_rready = 1; e_rresp = 1;
        if (ri == 0 || ri == 3 || ri == 4 || ri == 5) e_rdata = m_reg[ri];
        else if (ri == 2) e_rdata = status_in;
        else begin
          e_rdata = '0;
          e_rresp = (ri == 1);
        end
      end
      if (w_open) begin
        if (w_age >= 1 && !write_req) w_open = 0;
        w_age++;
      end else if (write_req) begin
        wi = int'(write_addr) >> 2;
        w_open = 1; w_age = 0; e_wready = 1;
        for (int b = 0; b < 4; b++) mdl_m[8*b +: 8] = {8{s_axi_wstrb[b]}};
        e_wresp = (wi <= 5) && (wi != 2);
        if (wi == 0 || wi == 3 || wi == 5) m_reg[wi] = (m_reg[wi] & ~mdl_m) | (s_axi_wdata & mdl_m);
        else if (wi == 1) e_ctrl = s_axi_wdata & mdl_m;
        else if (wi == 4) mdl_w1c = s_axi_wdata & mdl_m;
      end
      m_reg[4] = (m_reg[4] & ~mdl_w1c) | irq_events;
    end
  end

  always @(negedge clk) begin
    check("cmp_write_ready", 32'(write_ready), 32'(e_wready));
    check("cmp_write_response", 32'(write_response), 32'(e_wresp));
    check("cmp_read_ready", 32'(read_ready), 32'(e_rready));
    check("cmp_read_value", read_value, e_rdata);
    check("cmp_read_response", 32'(read_response), 32'(e_rresp));
    check("cmp_cfg_out", cfg_out, m_reg[0]);
    check("cmp_ctrl_pulse", ctrl_pulse, e_ctrl);
    check("cmp_irq_out", 32'(irq_out), 32'(e_irq));
    if (write_ready) wr_pulses++;
  end

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int hold, input logic [31:0] ev,
                          output logic resp, output logic [31:0] ctrl_seen);
    @(posedge clk); #1;
    write_req = 1'b1; write_addr = addr; s_axi_wdata = data; s_axi_wstrb = strb; irq_events = ev;
    @(posedge clk); #1;
    s_axi_wdata = 32'hDEAD_DEAD; s_axi_wstrb = 4'hF; irq_events = '0;
    check("write_ready_latency", 32'(write_ready), 32'd1);
    resp = write_response;
    ctrl_seen = ctrl_pulse;
    repeat (hold) begin @(posedge clk); #1; end
    write_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [6:0] addr, output logic [31:0] data, output logic resp);
    @(posedge clk); #1;
    read_req = 1'b1; read_addr = addr;
    @(posedge clk); #1;
    check("read_ready_latency", 32'(read_ready), 32'd1);
    data = read_value;
    resp = read_response;
    read_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic        wresp, rresp, rresp2;
  logic [31:0] ctrl_seen, rdata, rdata2;
  int          pulses_before;

  initial begin
    rst_n = 1'b0; write_req = 1'b0; write_addr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    read_req = 1'b0; read_addr = '0; status_in = 32'hC0FF_EE01; irq_events = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cfg_out", cfg_out, 32'h0);
    check("reset_read_value", read_value, 32'h0);
    check("reset_irq_out", 32'(irq_out), 32'h0);
    check("reset_write_ready", 32'(write_ready), 32'h0);
    rst_n = 1'b1;

    do_write(7'h00, 32'hA5A5_1234, 4'hF, 0, '0, wresp, ctrl_seen);
    check("cfg_write_resp", 32'(wresp), 32'd1);
    check("cfg_out_value", cfg_out, 32'hA5A5_1234);
    do_read(7'h00, rdata, rresp);
    check("cfg_read_value", rdata, 32'hA5A5_1234);
    check("cfg_read_resp", 32'(rresp), 32'd1);

    pulses_before = wr_pulses;
    do_write(7'h14, 32'hFFFF_FFFF, 4'h3, 5, '0, wresp, ctrl_seen);
    check("scratch_single_pulse", 32'(wr_pulses - pulses_before), 32'd1);
    do_read(7'h14, rdata, rresp);
    check("scratch_strobed", rdata, 32'h0000_FFFF);

    do_write(7'h04, 32'h0000_0005, 4'hF, 0, '0, wresp, ctrl_seen);
    check("ctrl_pulse_value", ctrl_seen, 32'h5);
    check("ctrl_write_resp", 32'(wresp), 32'd1);
    check("ctrl_pulse_cleared", ctrl_pulse, 32'h0);
    do_read(7'h04, rdata, rresp);
    check("ctrl_read_zero", rdata, 32'h0);
    check("ctrl_read_resp", 32'(rresp), 32'd1);

    do_write(7'h08, 32'hFFFF_FFFF, 4'hF, 0, '0, wresp, ctrl_seen);
    check("status_write_slverr", 32'(wresp), 32'd0);
    do_write(7'h3C, 32'hFFFF_FFFF, 4'hF, 0, '0, wresp, ctrl_seen);
    check("unmapped_write_slverr", 32'(wresp), 32'd0);
    do_read(7'h3C, rdata, rresp);
    check("unmapped_read_value", rdata, 32'h0);
    check("unmapped_read_resp", 32'(rresp), 32'd0);
    do_read(7'h08, rdata, rresp);
    check("status_read_value", rdata, 32'hC0FF_EE01);
    do_read(7'h00, rdata, rresp);
    check("cfg_unchanged", rdata, 32'hA5A5_1234);
    do_read(7'h14, rdata, rresp);
    check("scratch_unchanged", rdata, 32'h0000_FFFF);

    do_write(7'h0C, 32'h0000_0008, 4'hF, 0, '0, wresp, ctrl_seen);
    @(posedge clk); #1; irq_events = 32'h8;
    @(posedge clk); #1; irq_events = '0;
    @(posedge clk); #1;
    check("irq_out_set", 32'(irq_out), 32'd1);
    do_read(7'h10, rdata, rresp);
    check("irq_flags_set", rdata, 32'h8);
    do_write(7'h10, 32'h0000_0008, 4'hF, 0, 32'h8, wresp, ctrl_seen);
    do_read(7'h10, rdata, rresp);
    check("irq_set_wins", rdata, 32'h8);
    check("irq_out_still_set", 32'(irq_out), 32'd1);
    do_write(7'h10, 32'h0000_0008, 4'hF, 0, '0, wresp, ctrl_seen);
    do_read(7'h10, rdata, rresp);
    check("irq_flags_cleared", rdata, 32'h0);
    check("irq_out_cleared", 32'(irq_out), 32'd0);
    do_write(7'h0C, 32'hFFFF_FF00, 4'b0010, 0, '0, wresp, ctrl_seen);
    do_read(7'h0C, rdata, rresp);
    check("mask_byte1_strobe", rdata, 32'h0000_FF08);

    fork
      do_write(7'h00, 32'h1111_2222, 4'hF, 0, '0, wresp, ctrl_seen);
      do_read(7'h00, rdata2, rresp2);
    join
    check("same_cycle_read_old", rdata2, 32'hA5A5_1234);
    check("same_cycle_cfg_new", cfg_out, 32'h1111_2222);

    @(posedge clk); #1;
    write_req = 1'b1; write_addr = 7'h00; s_axi_wdata = 32'h1357_9BDF; s_axi_wstrb = 4'hF;
    @(posedge clk); #1;
    check("pre_reset_ready", 32'(write_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(write_ready), 32'd0);
    check("async_reset_cfg", cfg_out, 32'h0);
    check("async_reset_read_value", read_value, 32'h0);
    write_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_write(7'h00, 32'h0BAD_F00D, 4'b1100, 0, '0, wresp, ctrl_seen);
    check("post_reset_resp", 32'(wresp), 32'd1);
    check("post_reset_cfg", cfg_out, 32'h0BAD_0000);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
